// File: rtl/cpu_mem_pkg.sv
// Types and helpers shared by the data- and instruction-side SRAM bridges.
// Each 32-bit CPU word is carried as a low and a high 16-bit half on the external bus.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  localparam int unsigned DEFAULT_WAIT = 1;

  function automatic logic [15:0] word_half(input logic [31:0] word, input logic half);
    return half ? word[31:16] : word[15:0];
  endfunction

  function automatic logic [1:0] we_half(input logic [3:0] we, input logic half);
    return half ? we[3:2] : we[1:0];
  endfunction

endpackage

// File: rtl/dmem_wait_ctr.sv
// Loadable 4-bit wait-state down-counter; zero marks the final cycle of a bus phase.
module dmem_wait_ctr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       zero
);

  logic [3:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/dmem_sram_bridge.sv
// CPU data-port responder: splits each 32-bit access into 16-bit phases on an
// asynchronous SRAM bus with WAIT extra cycles per phase; every output is registered.
module dmem_sram_bridge
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned WAIT   = DEFAULT_WAIT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [31:0]       i_addr_d,
  input  logic [3:0]        i_we_d,
  input  logic              i_rd_d,
  input  logic [31:0]       i_wdata_d,
  output logic [31:0]       o_rdata_d,
  output logic              o_valid_d,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [15:0]       o_mem_wdata,
  input  logic [15:0]       i_mem_rdata,
  output logic              o_mem_oe,
  output logic              o_mem_we,
  output logic [1:0]        o_mem_be
);

  localparam logic [3:0] WAIT_LD = 4'(WAIT);

  state_t state, state_nx;

  logic [ADDR_W-2:0] addr_q, addr_sel;
  logic [3:0]        we_q, we_sel;
  logic              wr_q, wr_sel;
  logic [31:0]       wdata_q, wdata_sel;
  logic [15:0]       lo_q;

  logic req, latch, ctr_load, ctr_zero, cap_lo, half_nx, in_phase_nx;

  logic [31:0]       rdata_nx;
  logic              valid_nx;
  logic [ADDR_W-1:0] mem_addr_nx;
  logic [15:0]       mem_wdata_nx;
  logic              mem_oe_nx, mem_we_nx;
  logic [1:0]        mem_be_nx;

  // The bus is word aligned and wraps at the SRAM size; the remaining address bits are dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr_d[31:ADDR_W+1], i_addr_d[1:0]};

  assign req = i_rd_d | (|i_we_d);

  dmem_wait_ctr u_wait_ctr (
    .clk      (i_clk),
    .rst_n    (i_rst),
    .load     (ctr_load),
    .load_val (WAIT_LD),
    .zero     (ctr_zero)
  );

  always_comb begin
    state_nx = state;
    latch    = 1'b0;
    ctr_load = 1'b0;
    cap_lo   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          latch    = 1'b1;
          ctr_load = 1'b1;
          // A write touching only the upper half has nothing to do in the low phase.
          if ((i_we_d[1:0] == 2'b00) && (i_we_d[3:2] != 2'b00)) state_nx = HI;
          else                                                   state_nx = LO;
        end
      end
      LO: begin
        if (ctr_zero) begin
          cap_lo = 1'b1;
          if (wr_q && (we_q[3:2] == 2'b00)) begin
            state_nx = DONE;
          end else begin
            state_nx = HI;
            ctr_load = 1'b1;
          end
        end
      end
      HI: begin
        if (ctr_zero) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // On the request edge the latches are not loaded yet, so phase outputs use the live inputs.
  always_comb begin
    addr_sel  = latch ? i_addr_d[ADDR_W:2] : addr_q;
    we_sel    = latch ? i_we_d             : we_q;
    wr_sel    = latch ? (|i_we_d)          : wr_q;
    wdata_sel = latch ? i_wdata_d          : wdata_q;

    half_nx     = (state_nx == HI) ? HALF_HI : HALF_LO;
    in_phase_nx = (state_nx == LO) || (state_nx == HI);

    mem_addr_nx  = '0;
    mem_wdata_nx = '0;
    mem_oe_nx    = 1'b0;
    mem_we_nx    = 1'b0;
    mem_be_nx    = 2'b00;
    if (in_phase_nx) begin
      mem_addr_nx = {addr_sel, half_nx};
      if (wr_sel) begin
        mem_we_nx    = 1'b1;
        mem_be_nx    = we_half(we_sel, half_nx);
        mem_wdata_nx = word_half(wdata_sel, half_nx);
      end else begin
        mem_oe_nx = 1'b1;
        mem_be_nx = 2'b11;
      end
    end

    valid_nx = (state_nx == DONE);
    rdata_nx = '0;
    if ((state_nx == DONE) && !wr_q) rdata_nx = {i_mem_rdata, lo_q};
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      we_q    <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      lo_q    <= '0;
    end else begin
      state <= state_nx;
      if (latch) begin
        addr_q  <= i_addr_d[ADDR_W:2];
        we_q    <= i_we_d;
        wr_q    <= |i_we_d;
        wdata_q <= i_wdata_d;
      end
      if (cap_lo) lo_q <= i_mem_rdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_rdata_d   <= '0;
      o_valid_d   <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_oe    <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_be    <= 2'b00;
    end else begin
      o_rdata_d   <= rdata_nx;
      o_valid_d   <= valid_nx;
      o_mem_addr  <= mem_addr_nx;
      o_mem_wdata <= mem_wdata_nx;
      o_mem_oe    <= mem_oe_nx;
      o_mem_we    <= mem_we_nx;
      o_mem_be    <= mem_be_nx;
    end
  end

endmodule

// File: tb/tb_dmem_sram_bridge.sv
// Directed bench for dmem_sram_bridge: three instances (WAIT = 0, 1, 3), each on its own SRAM model.
// Latency is counted as posedges from the request edge to the edge where the CPU sees o_valid_d.
module tb_dmem_sram_bridge;

  localparam int AW = 10;

  logic clk;
  logic rst_n;

  logic [31:0]   addr_d    [3];
  logic [3:0]    we_d      [3];
  logic          rd_d      [3];
  logic [31:0]   wdata_d   [3];
  logic [31:0]   rdata_d   [3];
  logic          valid_d   [3];
  logic [AW-1:0] mem_addr  [3];
  logic [15:0]   mem_wdata [3];
  logic [15:0]   mem_rdata [3];
  logic          mem_oe    [3];
  logic          mem_we    [3];
  logic [1:0]    mem_be    [3];

  logic [15:0] mem [3][1024];

  int vec_cnt;
  int err_cnt;

  logic [AW-1:0] t_addr [40];
  logic [1:0]    t_be   [40];
  logic          t_oe   [40];
  logic          t_we   [40];
  logic [15:0]   t_wd   [40];
  int            ncyc;
  int            valid_at;
  logic [31:0]   valid_rdata;
  bit            idle_ok;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  dmem_sram_bridge #(.ADDR_W(AW), .WAIT(0)) u_w0 (
    .i_clk(clk), .i_rst(rst_n), .i_addr_d(addr_d[0]), .i_we_d(we_d[0]), .i_rd_d(rd_d[0]),
    .i_wdata_d(wdata_d[0]), .o_rdata_d(rdata_d[0]), .o_valid_d(valid_d[0]),
    .o_mem_addr(mem_addr[0]), .o_mem_wdata(mem_wdata[0]), .i_mem_rdata(mem_rdata[0]),
    .o_mem_oe(mem_oe[0]), .o_mem_we(mem_we[0]), .o_mem_be(mem_be[0]));

  dmem_sram_bridge #(.ADDR_W(AW), .WAIT(1)) u_w1 (
    .i_clk(clk), .i_rst(rst_n), .i_addr_d(addr_d[1]), .i_we_d(we_d[1]), .i_rd_d(rd_d[1]),
    .i_wdata_d(wdata_d[1]), .o_rdata_d(rdata_d[1]), .o_valid_d(valid_d[1]),
    .o_mem_addr(mem_addr[1]), .o_mem_wdata(mem_wdata[1]), .i_mem_rdata(mem_rdata[1]),
    .o_mem_oe(mem_oe[1]), .o_mem_we(mem_we[1]), .o_mem_be(mem_be[1]));

  dmem_sram_bridge #(.ADDR_W(AW), .WAIT(3)) u_w3 (
    .i_clk(clk), .i_rst(rst_n), .i_addr_d(addr_d[2]), .i_we_d(we_d[2]), .i_rd_d(rd_d[2]),
    .i_wdata_d(wdata_d[2]), .o_rdata_d(rdata_d[2]), .o_valid_d(valid_d[2]),
    .o_mem_addr(mem_addr[2]), .o_mem_wdata(mem_wdata[2]), .i_mem_rdata(mem_rdata[2]),
    .o_mem_oe(mem_oe[2]), .o_mem_we(mem_we[2]), .o_mem_be(mem_be[2]));

  // ---------------- SRAM models (contents preloaded while reset is low) ----------------
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        mem[i][10'h082] <= 16'hBEEF;
        mem[i][10'h083] <= 16'hDEAD;
        mem[i][10'h008] <= 16'h1111;
        mem[i][10'h009] <= 16'h2222;
        mem[i][10'h028] <= 16'h4444;
        mem[i][10'h029] <= 16'h3333;
      end else if (mem_we[i]) begin
        if (mem_be[i][0]) mem[i][mem_addr[i]][7:0]  <= mem_wdata[i][7:0];
        if (mem_be[i][1]) mem[i][mem_addr[i]][15:8] <= mem_wdata[i][15:8];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      mem_rdata[i] = mem_oe[i] ? mem[i][mem_addr[i]] : 16'h0000;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_inputs(input int idx);
    addr_d[idx]  = '0;
    we_d[idx]    = '0;
    rd_d[idx]    = 1'b0;
    wdata_d[idx] = '0;
  endtask

  // Called at a negedge: presents a request, records the bus trace until o_valid_d,
  // then samples the following cycle, which must be idle.
  task automatic do_access(input int idx, input logic [31:0] a, input logic [3:0] w,
                           input logic r, input logic [31:0] d, input bit hold);
    addr_d[idx]  = a;
    we_d[idx]    = w;
    rd_d[idx]    = r;
    wdata_d[idx] = d;
    valid_at     = -1;
    valid_rdata  = '0;
    ncyc         = 0;
    idle_ok      = 1'b0;
    @(posedge clk);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0 && !hold) clear_inputs(idx);
      t_addr[c] = mem_addr[idx];
      t_be[c]   = mem_be[idx];
      t_oe[c]   = mem_oe[idx];
      t_we[c]   = mem_we[idx];
      t_wd[c]   = mem_wdata[idx];
      ncyc      = c + 1;
      if (valid_d[idx]) begin
        valid_at    = c + 1;
        valid_rdata = rdata_d[idx];
        break;
      end
    end
    if (valid_at > 0) begin
      @(negedge clk);
      idle_ok = !mem_oe[idx] && !mem_we[idx] && (mem_be[idx] == 2'b00) && !valid_d[idx];
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [62:0] obs;
    #2 rst_n = 1'b0;
    #2;
    for (int i = 0; i < 3; i++) begin
      obs = {rdata_d[i], valid_d[i], mem_addr[i], mem_wdata[i], mem_oe[i], mem_we[i], mem_be[i]};
      vec_cnt++;
      if (obs !== '0) begin
        err_cnt++;
        $display("FAIL reset_outputs[%0d]: got %h want 0", i, obs);
      end
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_full_read();
    @(negedge clk);
    do_access(1, 32'h0000_0104, 4'b0000, 1'b1, 32'h0, 1'b0);
    vec_cnt++;
    if (valid_at !== 5) begin
      err_cnt++; $display("FAIL full_read_latency: got %0d want 5", valid_at);
    end
    vec_cnt++;
    if (valid_rdata !== 32'hDEADBEEF) begin
      err_cnt++; $display("FAIL full_read_data: got %h want deadbeef", valid_rdata);
    end
    vec_cnt++;
    if ({t_addr[0], t_addr[1], t_addr[2], t_addr[3]} !== {10'h082, 10'h082, 10'h083, 10'h083}) begin
      err_cnt++;
      $display("FAIL full_read_addr_seq: got %h %h %h %h want 082 082 083 083",
               t_addr[0], t_addr[1], t_addr[2], t_addr[3]);
    end
    vec_cnt++;
    if ({t_oe[0], t_oe[1], t_oe[2], t_oe[3], t_be[0], t_be[3]} !== 8'b1111_1111) begin
      err_cnt++;
      $display("FAIL full_read_oe_be: got oe=%b%b%b%b be0=%b be3=%b want 1111 11 11",
               t_oe[0], t_oe[1], t_oe[2], t_oe[3], t_be[0], t_be[3]);
    end
    vec_cnt++;
    if (idle_ok !== 1'b1) begin
      err_cnt++; $display("FAIL full_read_idle_after: got %b want 1", idle_ok);
    end
  endtask

  task automatic test_addr_wrap();
    @(negedge clk);
    do_access(1, 32'h0000_0904, 4'b0000, 1'b1, 32'h0, 1'b0);
    vec_cnt++;
    if ({t_addr[0], valid_rdata} !== {10'h082, 32'hDEADBEEF}) begin
      err_cnt++;
      $display("FAIL addr_wrap: got addr=%h data=%h want 082 deadbeef", t_addr[0], valid_rdata);
    end
  endtask

  task automatic test_byte_write();
    @(negedge clk);
    do_access(1, 32'h0000_0010, 4'b0100, 1'b0, 32'h00AB_0000, 1'b0);
    vec_cnt++;
    if (valid_at !== 3) begin
      err_cnt++; $display("FAIL byte_write_latency: got %0d want 3", valid_at);
    end
    for (int c = 0; c < 2; c++) begin
      vec_cnt++;
      if ({t_addr[c], t_be[c], t_wd[c], t_we[c], t_oe[c]} !== {10'h009, 2'b01, 16'h00AB, 1'b1, 1'b0}) begin
        err_cnt++;
        $display("FAIL byte_write_phase[%0d]: got addr=%h be=%b wd=%h we=%b oe=%b want 009 01 00ab 1 0",
                 c, t_addr[c], t_be[c], t_wd[c], t_we[c], t_oe[c]);
      end
    end
    vec_cnt++;
    if (valid_rdata !== 32'h0) begin
      err_cnt++; $display("FAIL byte_write_rdata: got %h want 0", valid_rdata);
    end
    do_access(1, 32'h0000_0010, 4'b0000, 1'b1, 32'h0, 1'b0);
    vec_cnt++;
    if (valid_rdata !== 32'h22AB_1111) begin
      err_cnt++; $display("FAIL byte_write_readback: got %h want 22ab1111", valid_rdata);
    end
  endtask

  task automatic test_low_half_write();
    @(negedge clk);
    do_access(1, 32'h0000_0050, 4'b0011, 1'b0, 32'h0000_9876, 1'b0);
    vec_cnt++;
    if (valid_at !== 3) begin
      err_cnt++; $display("FAIL low_write_latency: got %0d want 3", valid_at);
    end
    vec_cnt++;
    if ({t_addr[1], t_be[1], t_wd[1], t_we[1]} !== {10'h028, 2'b11, 16'h9876, 1'b1}) begin
      err_cnt++;
      $display("FAIL low_write_phase: got addr=%h be=%b wd=%h we=%b want 028 11 9876 1",
               t_addr[1], t_be[1], t_wd[1], t_we[1]);
    end
    do_access(1, 32'h0000_0050, 4'b0000, 1'b1, 32'h0, 1'b0);
    vec_cnt++;
    if (valid_rdata !== 32'h3333_9876) begin
      err_cnt++; $display("FAIL low_write_readback: got %h want 33339876", valid_rdata);
    end
  endtask

  task automatic test_rd_wr_collision();
    int oe_cnt;
    int we_cnt;
    @(negedge clk);
    do_access(1, 32'h0000_0020, 4'hF, 1'b1, 32'h1234_5678, 1'b0);
    oe_cnt = 0;
    we_cnt = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (t_oe[c]) oe_cnt++;
      if (t_we[c]) we_cnt++;
    end
    vec_cnt++;
    if ({oe_cnt, we_cnt, valid_at} !== {32'd0, 32'd4, 32'd5}) begin
      err_cnt++;
      $display("FAIL collision_bus: got oe_cycles=%0d we_cycles=%0d latency=%0d want 0 4 5",
               oe_cnt, we_cnt, valid_at);
    end
    vec_cnt++;
    if (valid_rdata !== 32'h0) begin
      err_cnt++; $display("FAIL collision_rdata: got %h want 0", valid_rdata);
    end
    do_access(1, 32'h0000_0020, 4'b0000, 1'b1, 32'h0, 1'b0);
    vec_cnt++;
    if (valid_rdata !== 32'h1234_5678) begin
      err_cnt++; $display("FAIL collision_readback: got %h want 12345678", valid_rdata);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    do_access(0, 32'h0000_0104, 4'b0000, 1'b1, 32'h0, 1'b1);
    vec_cnt++;
    if ({valid_at, valid_rdata} !== {32'd3, 32'hDEADBEEF}) begin
      err_cnt++;
      $display("FAIL b2b_read: got latency=%0d data=%h want 3 deadbeef", valid_at, valid_rdata);
    end
    vec_cnt++;
    if (idle_ok !== 1'b1) begin
      err_cnt++; $display("FAIL b2b_held_request_reissued: got idle=%b want 1", idle_ok);
    end
    do_access(0, 32'h0000_0030, 4'hF, 1'b0, 32'hCAFE_F00D, 1'b0);
    vec_cnt++;
    if (valid_at !== 3) begin
      err_cnt++; $display("FAIL b2b_write_latency: got %0d want 3", valid_at);
    end
    vec_cnt++;
    if ({t_addr[0], t_wd[0], t_addr[1], t_wd[1]} !== {10'h018, 16'hF00D, 10'h019, 16'hCAFE}) begin
      err_cnt++;
      $display("FAIL b2b_write_phases: got %h:%h %h:%h want 018:f00d 019:cafe",
               t_addr[0], t_wd[0], t_addr[1], t_wd[1]);
    end
    do_access(0, 32'h0000_0030, 4'b0000, 1'b1, 32'h0, 1'b0);
    vec_cnt++;
    if (valid_rdata !== 32'hCAFE_F00D) begin
      err_cnt++; $display("FAIL b2b_readback: got %h want cafef00d", valid_rdata);
    end
  endtask

  task automatic test_wait3_write();
    int lo_cnt;
    int hi_cnt;
    @(negedge clk);
    do_access(2, 32'h0000_0040, 4'hF, 1'b0, 32'hA5A5_5A5A, 1'b0);
    lo_cnt = 0;
    hi_cnt = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (t_we[c] && t_addr[c] == 10'h020) lo_cnt++;
      if (t_we[c] && t_addr[c] == 10'h021) hi_cnt++;
    end
    vec_cnt++;
    if (valid_at !== 9) begin
      err_cnt++; $display("FAIL wait3_latency: got %0d want 9", valid_at);
    end
    vec_cnt++;
    if ({lo_cnt, hi_cnt} !== {32'd4, 32'd4}) begin
      err_cnt++; $display("FAIL wait3_we_cycles: got lo=%0d hi=%0d want 4 4", lo_cnt, hi_cnt);
    end
    do_access(2, 32'h0000_0040, 4'b0000, 1'b1, 32'h0, 1'b0);
    vec_cnt++;
    if ({valid_at, valid_rdata} !== {32'd9, 32'hA5A5_5A5A}) begin
      err_cnt++;
      $display("FAIL wait3_readback: got latency=%0d data=%h want 9 a5a55a5a", valid_at, valid_rdata);
    end
  endtask

  task automatic test_reset_mid_phase();
    logic [62:0] obs;
    int pulses;
    @(negedge clk);
    addr_d[1] = 32'h0000_0104;
    rd_d[1]   = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) clear_inputs(1);
    end
    vec_cnt++;
    if ({mem_oe[1], mem_addr[1]} !== {1'b1, 10'h083}) begin
      err_cnt++;
      $display("FAIL midreset_in_hi: got oe=%b addr=%h want 1 083", mem_oe[1], mem_addr[1]);
    end
    #1 rst_n = 1'b0;
    #1;
    obs = {rdata_d[1], valid_d[1], mem_addr[1], mem_wdata[1], mem_oe[1], mem_we[1], mem_be[1]};
    vec_cnt++;
    if (obs !== '0) begin
      err_cnt++; $display("FAIL midreset_async_clear: got %h want 0", obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (valid_d[1]) pulses++;
    end
    vec_cnt++;
    if (pulses !== 0) begin
      err_cnt++; $display("FAIL midreset_no_valid: got %0d pulses want 0", pulses);
    end
    do_access(1, 32'h0000_0104, 4'b0000, 1'b1, 32'h0, 1'b0);
    vec_cnt++;
    if ({valid_at, valid_rdata} !== {32'd5, 32'hDEADBEEF}) begin
      err_cnt++;
      $display("FAIL midreset_fresh_read: got latency=%0d data=%h want 5 deadbeef", valid_at, valid_rdata);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst_n   = 1'b1;
    for (int i = 0; i < 3; i++) clear_inputs(i);
    test_reset();
    test_full_read();
    test_addr_wrap();
    test_byte_write();
    test_low_half_write();
    test_rd_wr_collision();
    test_back_to_back();
    test_wait3_write();
    test_reset_mid_phase();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
